// File: rtl/arb_mux4_pkg.sv
// arb_mux4_pkg
//   Shared definitions for the 4-way round-robin arbiter/mux:
//   FSM state encoding, default parameter values and the round-robin
//   search helper used by arb_mux4.
package arb_mux4_pkg;

    localparam int DEF_W        = 8;
    localparam int DEF_HOLD_MAX = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Result of one round-robin search.
    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // First set bit of r, searching upward from index p and wrapping 3->0.
    // The loop runs from the far end so the nearest hit is written last.
    function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] p);
        pick_t      res;
        logic [1:0] i;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            i = p + 2'(k);
            if (r[i]) begin
                res.found = 1'b1;
                res.idx   = i;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4x1.sv
// mux4x1
//   Single-bit 4:1 multiplexer.
//   din  [3:0] : candidate bits, din[i] selected when sel == i
//   sel  [1:0] : select
//   dout       : selected bit
module mux4x1 (
    input  logic [3:0] din,
    input  logic [1:0] sel,
    output logic       dout
);

    assign dout = din[sel];

endmodule

// File: rtl/arb_mux4.sv
// arb_mux4
//   Four-requester round-robin arbiter driving a shared registered data mux.
//   An owner keeps the grant while it requests, for at most HOLD_MAX
//   consecutive cycles; on release the next owner is chosen on the same edge
//   so back-to-back requesters see no idle gap.
//
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req  [3:0] : request vector
//   din  [4W]  : requester data, requester i on [i*W +: W]
//   gnt  [3:0] : registered one-hot grant, zero when idle
//   sel  [1:0] : registered owner index, holds last owner when idle
//   dout [W]   : registered muxed data (one cycle behind sel)
//   dout_valid : registered, dout carries granted data
//   busy       : FSM is in GRANT
module arb_mux4
    import arb_mux4_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] din,
    output logic [3:0]     gnt,
    output logic [1:0]     sel,
    output logic [W-1:0]   dout,
    output logic           dout_valid,
    output logic           busy
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_e     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [3:0] hold_cnt, hold_n;
    logic [3:0] gnt_n;
    logic [1:0] sel_n;
    pick_t      pick_idle, pick_rel;

    // ---------------- datapath: W bit-slices of mux4x1 ----------------
    logic [W-1:0][3:0] lane_din;
    logic [W-1:0]      mux_out;

    for (genvar b = 0; b < W; b++) begin : g_lane
        assign lane_din[b] = {din[3*W+b], din[2*W+b], din[W+b], din[b]};
        mux4x1 u_mux (
            .din  (lane_din[b]),
            .sel  (sel),
            .dout (mux_out[b])
        );
    end

    // ---------------- arbitration / next state ----------------
    assign pick_idle = rr_pick(req, ptr);
    // On release the search starts just past the owner, so a force-released
    // owner that still requests is reached last.
    assign pick_rel  = rr_pick(req, sel + 2'd1);

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = sel;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        unique case (state)
            IDLE: begin
                if (pick_idle.found) begin
                    state_n = GRANT;
                    gnt_n   = 4'b0001 << pick_idle.idx;
                    sel_n   = pick_idle.idx;
                    hold_n  = '0;
                end
            end
            GRANT: begin
                if (req[sel] && (hold_cnt < HOLD_LAST)) begin
                    hold_n = hold_cnt + 4'd1;
                end else begin
                    ptr_n  = sel + 2'd1;
                    hold_n = '0;
                    if (pick_rel.found) begin
                        gnt_n = 4'b0001 << pick_rel.idx;
                        sel_n = pick_rel.idx;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            sel        <= '0;
            ptr        <= '0;
            hold_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            sel        <= sel_n;
            ptr        <= ptr_n;
            hold_cnt   <= hold_n;
            // Sampled with the pre-edge sel/state so the final granted word
            // is still flagged valid on the edge that leaves GRANT.
            dout       <= mux_out;
            dout_valid <= (state == GRANT);
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_arb_mux4.sv
module tb_arb_mux4;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req;
    logic [4*W-1:0] din;
    logic [3:0]     gnt;
    logic [1:0]     sel;
    logic [W-1:0]   dout;
    logic           dout_valid;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    arb_mux4 #(.W(W), .HOLD_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Return 1 time unit after a rising edge: outputs settled, inputs safe.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst_n = 1'b0;
        req   = r;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        do_reset(4'b1111);
        rst_n = 1'b0;
        tick();
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", dout); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL first_gnt got=%b exp=0001", gnt); end
        n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL first_sel got=%0d exp=0", sel); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy got=%b exp=1", busy); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid got=%b exp=0", dout_valid); end
        tick();
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL second_valid got=%b exp=1", dout_valid); end
        n_checks++; if (dout !== 8'h11) begin n_fail++; $display("FAIL second_dout got=%h exp=11", dout); end
    endtask

    // All four requesting: each owner 4 cycles, rotation 0,1,2,3,0 with no gap.
    task automatic test_rotation();
        logic [7:0] slice [4];
        int         own, prev_own;
        slice[0] = 8'h11; slice[1] = 8'h22; slice[2] = 8'h33; slice[3] = 8'h44;
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        do_reset(4'b0000);
        req = 4'b1111;
        for (int n = 1; n <= 20; n++) begin
            tick();
            own = ((n - 1) / 4) % 4;
            n_checks++; if (gnt !== (4'b0001 << own)) begin n_fail++; $display("FAIL rot_gnt edge=%0d got=%b exp_owner=%0d", n, gnt, own); end
            n_checks++; if (sel !== 2'(own)) begin n_fail++; $display("FAIL rot_sel edge=%0d got=%0d exp=%0d", n, sel, own); end
            if (n >= 2) begin
                prev_own = ((n - 2) / 4) % 4;
                n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL rot_valid edge=%0d got=%b exp=1", n, dout_valid); end
                n_checks++; if (dout !== slice[prev_own]) begin n_fail++; $display("FAIL rot_dout edge=%0d got=%h exp=%h", n, dout, slice[prev_own]); end
            end
        end
    endtask

    // Lone requester 2: forced release re-grants immediately, dout tracks din[2].
    task automatic test_single();
        logic [7:0] v;
        din = '0;
        do_reset(4'b0000);
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            v = 8'h10 + 8'(i);
            din[2*W +: W] = v;
            tick();
            n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt cyc=%0d got=%b exp=0100", i, gnt); end
            if (i >= 1) begin
                n_checks++; if (dout !== v) begin n_fail++; $display("FAIL single_dout cyc=%0d got=%h exp=%h", i, dout, v); end
                n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid cyc=%0d got=%b exp=1", i, dout_valid); end
            end
            if (i == 4) begin
                n_checks++; if (dut.hold_cnt !== 4'd0) begin n_fail++; $display("FAIL single_regrant_hold got=%0d exp=0", dut.hold_cnt); end
            end
        end
    endtask

    // Owner 1 drops after 2 cycles; search from ptr=2 finds 3, not 0.
    task automatic test_handover();
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        do_reset(4'b0000);
        req = 4'b1010;
        tick();
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL ho_first got=%b exp=0010", gnt); end
        tick();
        req = 4'b1001;
        tick();
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL ho_gnt got=%b exp=1000", gnt); end
        n_checks++; if (sel !== 2'd3) begin n_fail++; $display("FAIL ho_sel got=%0d exp=3", sel); end
        n_checks++; if (dut.hold_cnt !== 4'd0) begin n_fail++; $display("FAIL ho_hold got=%0d exp=0", dut.hold_cnt); end
        n_checks++; if (dut.ptr !== 2'd2) begin n_fail++; $display("FAIL ho_ptr got=%0d exp=2", dut.ptr); end
        n_checks++; if (dout !== 8'h22) begin n_fail++; $display("FAIL ho_last_dout got=%h exp=22", dout); end
        // Non-owner req churn must not move the grant.
        req = 4'b1000;
        tick();
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL ho_churn1 got=%b exp=1000", gnt); end
        req = 4'b1111;
        tick();
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL ho_churn2 got=%b exp=1000", gnt); end
        n_checks++; if (dout !== 8'h44) begin n_fail++; $display("FAIL ho_dout got=%h exp=44", dout); end
    endtask

    // Data latency and drain to idle.
    task automatic test_idle_drain();
        din = {8'h44, 8'h33, 8'h22, 8'hA5};
        do_reset(4'b0000);
        req = 4'b0001;
        tick();
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL drain_gnt got=%b exp=0001", gnt); end
        tick();
        n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL drain_dout got=%h exp=a5", dout); end
        req = 4'b0000;
        tick();
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL drain_gnt0 got=%b exp=0000", gnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_busy got=%b exp=0", busy); end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL drain_last_valid got=%b exp=1", dout_valid); end
        n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL drain_last_dout got=%h exp=a5", dout); end
        tick();
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid0 got=%b exp=0", dout_valid); end
        n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL drain_sel_hold got=%0d exp=0", sel); end
    endtask

    // Async reset pulse between edges mid-grant, then resume from ptr=0.
    task automatic test_async_reset();
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        do_reset(4'b0000);
        req = 4'b0110;
        tick();
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL ar_pre1 got=%b exp=0010", gnt); end
        req = 4'b0100;
        tick();
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL ar_pre2 got=%b exp=0100", gnt); end
        req = 4'b0110;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL ar_gnt got=%b exp=0000", gnt); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got=%b exp=0", dout_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got=%b exp=0", busy); end
        n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL ar_sel got=%0d exp=0", sel); end
        #1 rst_n = 1'b1;
        tick();
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL ar_resume got=%b exp=0010", gnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        din   = '0;
        test_reset();
        test_rotation();
        test_single();
        test_handover();
        test_idle_drain();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_mux4.md
ARB_MUX4 -- requirements
Module: arb_mux4

Interface
- REQ-001: Parameter W, default 8; data width per requester.
- REQ-002: Parameter HOLD_MAX, default 4; maximum consecutive grant cycles per owner, legal range 1..15.
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: req  input  4  request vector; bit i high = requester i wants the shared mux.
- REQ-006: din  input  4*W  requester data; requester i on bits [i*W +: W].
- REQ-007: gnt  output  4  registered one-hot grant; all-zero when idle.
- REQ-008: sel  output  2  registered mux select, equal to index of set gnt bit; holds last owner when idle.
- REQ-009: dout  output  W  registered muxed data.
- REQ-010: dout_valid  output  1  registered; high when dout carries granted data.
- REQ-011: busy  output  1  high while in GRANT state.

Function
- REQ-012: The FSM SHALL have two states: IDLE and GRANT.
- REQ-013: Arbitration SHALL be round-robin: search starts at index ptr, wraps 3->0, and picks the first set req bit.
- REQ-014: In IDLE, any set req bit at a rising edge SHALL load gnt/sel with the winner, clear hold_cnt to 0, and enter GRANT the same edge.
- REQ-015: In GRANT with req[sel] high and hold_cnt < HOLD_MAX-1, the owner SHALL be kept and hold_cnt SHALL increment by 1.
- REQ-016: Release SHALL occur when req[sel] is low, or when hold_cnt == HOLD_MAX-1 (forced release).
- REQ-017: On release, ptr SHALL become sel+1 mod 4 and arbitration SHALL run on the same edge over the current req vector.
  - If a winner exists: stay in GRANT with the new owner and hold_cnt = 0 (zero-gap handover).
  - Otherwise: go to IDLE with gnt = 0.
- REQ-018: A force-released owner still requesting SHALL be re-granted only if no other requester is set (lowest priority after wrap).
- REQ-019: ptr SHALL update only on release; IDLE entry from reset uses ptr = 0.
- REQ-020: Each edge, dout SHALL load din[sel*W +: W] and dout_valid SHALL load (state == GRANT).
  - Latency: dout reflects the granted requester's din one cycle after gnt asserts.
  - The last granted word SHALL still be emitted valid on the edge the FSM leaves GRANT.
- REQ-021: Changes on req bits of non-owners SHALL NOT disturb the current grant.
- REQ-022: gnt SHALL never have more than one bit set.
- REQ-023: hold_cnt width SHALL be 4 bits; no wrap is reachable within the legal HOLD_MAX range.

Reset
- REQ-024: While rst_n is low: state = IDLE, gnt = 0, sel = 0, ptr = 0, hold_cnt = 0, dout = 0, dout_valid = 0, busy = 0.
- REQ-025: Reset asserted mid-grant SHALL clear all outputs immediately, without waiting for clk.
- REQ-026: After deassertion, arbitration SHALL resume from ptr = 0 on the first rising edge.

Structure
- REQ-027: A shared header SHALL hold the state encodings (IDLE = 1'b0, GRANT = 1'b1) and the default W and HOLD_MAX values.
- REQ-028: The datapath SHALL reuse the team's existing 1-bit mux4x1 (4-bit din, 2-bit sel, 1-bit dout), instantiated W times via generate.
- REQ-029: The FSM, round-robin logic and output registers SHALL live in arb_mux4 itself; no other sub-modules.

Verification
- REQ-030: Reset with req = 4'b1111, release rst_n -> gnt = 0001, sel = 0 after the first edge; dout_valid = 1 one edge later.
- REQ-031: req = 4'b1111 held, HOLD_MAX = 4 -> grants rotate 0001, 0010, 0100, 1000, 0001, each owner exactly 4 cycles, no idle gap.
- REQ-032: req = 4'b0100 only, held 10 cycles -> gnt = 0100 continuously; the forced release re-grants with no gap; dout tracks din[2].
- REQ-033: Owner 1 drops req after 2 cycles while req[3] is high -> next edge gnt = 1000 with hold_cnt = 0; ptr = 2 is used for that search.
- REQ-034: din slice 0 = 8'hA5 with gnt = 0001 -> dout = 8'hA5 one cycle later; when all req drop, gnt = 0 next edge and dout_valid falls one edge after.
- REQ-035: Pulse rst_n low mid-grant between clock edges -> gnt, dout_valid and busy go to 0 immediately; after release, the first grant uses ptr = 0.
